// File: rtl/sprite_blitter_if.sv
// Command bus between the game controller and the sprite blitter.
//   master : controller side. Drives cmd_* and samples waitrequest and done.
//   slave  : blitter side. Samples cmd_* and drives waitrequest and done.
// A command transfers in any cycle where cmd_valid=1 and waitrequest=0.
interface sprite_blitter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int S_W      = 6
);
  logic                cmd_valid;
  logic [1:0]          cmd_op;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [X_W-1:0]      cmd_w;
  logic [Y_W-1:0]      cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [S_W-1:0]      cmd_sprite;
  logic                cmd_transp;
  logic                waitrequest;
  logic                done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
           cmd_colour, cmd_sprite, cmd_transp,
    input  waitrequest, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
           cmd_colour, cmd_sprite, cmd_transp,
    output waitrequest, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Pixel-plotting engine that sits between the game controller and the VGA adapter.
// It takes one command at a time (CLEAR, RECT, SPRITE) and emits one pixel per
// cycle in raster order on the vga_* plot interface.
// Ports:
//   clk, rst_n  : clock; synchronous active-low reset
//   cmd         : command bus (slave modport); waitrequest and done are outputs
//   rom_addr    : sprite ROM address; rom_q returns the data one cycle later
//   rom_q       : sprite ROM data
//   vga_x/vga_y : plot coordinates; vga_colour : plot colour; vga_plot : strobe
module sprite_blitter #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int SPR_W      = 11,
  parameter int SPR_H      = 16,
  parameter int N_SPR      = 53,
  parameter int BACK_IDX   = 52,
  parameter int COLOUR_W   = 3,
  parameter int TRANSP_KEY = 0,
  parameter int X_W        = $clog2(SCREEN_W),
  parameter int Y_W        = $clog2(SCREEN_H),
  parameter int S_W        = $clog2(N_SPR),
  parameter int A_W        = $clog2(N_SPR*SPR_W*SPR_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  sprite_blitter_if.slave     cmd,
  output logic [A_W-1:0]      rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  // One extra bit on the scan coordinates lets regions run past the screen
  // edge without wrapping, so clipping is a plain magnitude compare.
  localparam int XS_W    = X_W + 1;
  localparam int YS_W    = Y_W + 1;
  localparam int SPR_PIX = SPR_W * SPR_H;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_RECT   = 2'd1;
  localparam logic [1:0] OP_SPRITE = 2'd2;

  typedef enum logic [1:0] {IDLE, FILL, SPRITE, FINISH} state_t;

  state_t              state, state_d;
  logic                busy, busy_d;
  logic                done_q, done_d;
  logic                transp, transp_d;
  logic [XS_W-1:0]     sx, sx_d, x0, x0_d, x_end, x_end_d;
  logic [YS_W-1:0]     sy, sy_d, y_end, y_end_d;
  logic [A_W-1:0]      rom_addr_p0, rom_addr_d;
  logic                vld_p1, vld_d;
  logic                src_rom_p1, src_rom_d;
  logic [XS_W-1:0]     disp_x_p1, disp_x_d;
  logic [YS_W-1:0]     disp_y_p1, disp_y_d;
  logic [COLOUR_W-1:0] colour_hold, colour_hold_d;

  logic                empty;
  logic [XS_W-1:0]     org_x, ext_w;
  logic [YS_W-1:0]     org_y, ext_h;
  logic [A_W-1:0]      spr_idx, spr_base;
  logic [XS_W-1:0]     nx;
  logic [YS_W-1:0]     ny;
  logic                key_hit;

  // Command decode: region origin/extent, empty detection and sprite base.
  always_comb begin
    org_x = XS_W'(cmd.cmd_x);
    org_y = YS_W'(cmd.cmd_y);
    ext_w = XS_W'(cmd.cmd_w);
    ext_h = YS_W'(cmd.cmd_h);
    empty = 1'b0;
    case (cmd.cmd_op)
      OP_CLEAR: begin
        org_x = '0;
        org_y = '0;
        ext_w = XS_W'(SCREEN_W);
        ext_h = YS_W'(SCREEN_H);
      end
      OP_RECT:   empty = (cmd.cmd_w == '0) || (cmd.cmd_h == '0);
      OP_SPRITE: begin
        ext_w = XS_W'(SPR_W);
        ext_h = YS_W'(SPR_H);
      end
      default:   empty = 1'b1;
    endcase
    spr_idx = A_W'(cmd.cmd_sprite);
    if (spr_idx >= A_W'(N_SPR))
      spr_idx = A_W'(BACK_IDX);
    // Only multiply in the design; done once per command, addresses then step by 1.
    spr_base = spr_idx * A_W'(SPR_PIX);
  end

  // Raster successor of the current scan position.
  always_comb begin
    if (sx == x_end) begin
      nx = x0;
      ny = sy + YS_W'(1);
    end else begin
      nx = sx + XS_W'(1);
      ny = sy;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state;
    busy_d        = busy;
    done_d        = 1'b0;
    vld_d         = 1'b0;
    src_rom_d     = 1'b0;
    transp_d      = transp;
    sx_d          = sx;
    sy_d          = sy;
    x0_d          = x0;
    x_end_d       = x_end;
    y_end_d       = y_end;
    rom_addr_d    = rom_addr_p0;
    disp_x_d      = disp_x_p1;
    disp_y_d      = disp_y_p1;
    colour_hold_d = vga_colour;

    case (state)
      IDLE: begin
        if (cmd.cmd_valid && !busy) begin
          busy_d   = 1'b1;
          x0_d     = org_x;
          sx_d     = org_x;
          sy_d     = org_y;
          x_end_d  = org_x + ext_w - XS_W'(1);
          y_end_d  = org_y + ext_h - YS_W'(1);
          transp_d = cmd.cmd_transp && (cmd.cmd_op == OP_SPRITE);
          if (empty) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else if (cmd.cmd_op == OP_SPRITE) begin
            // First cycle only presents the address; pixels trail by one cycle.
            rom_addr_d = spr_base;
            state_d    = SPRITE;
          end else begin
            // Fills show pixel 0 straight out of the accept cycle.
            vld_d         = 1'b1;
            disp_x_d      = org_x;
            disp_y_d      = org_y;
            colour_hold_d = COLOUR_W'(cmd.cmd_colour);
            if (ext_w == XS_W'(1) && ext_h == YS_W'(1)) begin
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              state_d = FILL;
            end
          end
        end
      end

      FILL: begin
        vld_d    = 1'b1;
        sx_d     = nx;
        sy_d     = ny;
        disp_x_d = nx;
        disp_y_d = ny;
        if (nx == x_end && ny == y_end) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end

      SPRITE: begin
        // Scan position tracks the address stage; the display stage lags by one.
        vld_d     = 1'b1;
        src_rom_d = 1'b1;
        disp_x_d  = sx;
        disp_y_d  = sy;
        if (sx == x_end && sy == y_end) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          sx_d       = nx;
          sy_d       = ny;
          rom_addr_d = rom_addr_p0 + A_W'(1);
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Address stage (p0) and display stage (p1) registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done_q      <= 1'b0;
      transp      <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      x0          <= '0;
      x_end       <= '0;
      y_end       <= '0;
      rom_addr_p0 <= '0;
      vld_p1      <= 1'b0;
      src_rom_p1  <= 1'b0;
      disp_x_p1   <= '0;
      disp_y_p1   <= '0;
      colour_hold <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done_q      <= done_d;
      transp      <= transp_d;
      sx          <= sx_d;
      sy          <= sy_d;
      x0          <= x0_d;
      x_end       <= x_end_d;
      y_end       <= y_end_d;
      rom_addr_p0 <= rom_addr_d;
      vld_p1      <= vld_d;
      src_rom_p1  <= src_rom_d;
      disp_x_p1   <= disp_x_d;
      disp_y_p1   <= disp_y_d;
      colour_hold <= colour_hold_d;
    end
  end

  // rom_q arrives in the display cycle, so sprite colour and the transparency
  // decision come straight from it; colour_hold keeps the last colour when idle.
  assign key_hit    = transp && (rom_q == COLOUR_W'(TRANSP_KEY));
  assign vga_colour = src_rom_p1 ? rom_q : colour_hold;
  assign vga_plot   = vld_p1
                   && (disp_x_p1 < XS_W'(SCREEN_W))
                   && (disp_y_p1 < YS_W'(SCREEN_H))
                   && !(src_rom_p1 && key_hit);
  assign vga_x      = 8'(disp_x_p1);
  assign vga_y      = 7'(disp_y_p1);
  assign rom_addr   = rom_addr_p0;

  assign cmd.waitrequest = busy;
  assign cmd.done        = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: directed commands from the test plan followed by
// randomized back-to-back commands, each compared cycle by cycle against a
// reference model that derives every pixel from the region geometry.
module tb_sprite_blitter;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPR_W    = 11;
  localparam int SPR_H    = 16;
  localparam int N_SPR    = 53;
  localparam int BACK_IDX = 52;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int S_W      = 6;
  localparam int A_W      = 14;
  localparam int ROM_N    = N_SPR * SPR_W * SPR_H;

  typedef struct {
    int op;
    int x;
    int y;
    int w;
    int h;
    int colour;
    int spr;
    int transp;
  } cmd_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [A_W-1:0]      rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic [COLOUR_W-1:0] rom [ROM_N];

  int checks   = 0;
  int failures = 0;

  sprite_blitter_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .S_W(S_W)) bus ();

  sprite_blitter #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .N_SPR(N_SPR), .BACK_IDX(BACK_IDX), .COLOUR_W(COLOUR_W), .TRANSP_KEY(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bus),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM, one cycle of latency.
  always @(posedge clk)
    rom_q <= (int'(rom_addr) < ROM_N) ? rom[rom_addr] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input cmd_t c, input bit v);
    bus.cmd_valid  = v;
    bus.cmd_op     = 2'(c.op);
    bus.cmd_x      = 8'(c.x);
    bus.cmd_y      = 7'(c.y);
    bus.cmd_w      = 8'(c.w);
    bus.cmd_h      = 7'(c.h);
    bus.cmd_colour = 3'(c.colour);
    bus.cmd_sprite = 6'(c.spr);
    bus.cmd_transp = 1'(c.transp);
  endtask

  function automatic cmd_t mk(input int op, input int x, input int y, input int w,
                              input int h, input int colour, input int spr, input int transp);
    cmd_t c;
    c.op = op; c.x = x; c.y = y; c.w = w; c.h = h;
    c.colour = colour; c.spr = spr; c.transp = transp;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op     = $urandom_range(1, 3);
    c.x      = ($urandom_range(0, 1) == 1) ? $urandom_range(140, 255) : $urandom_range(0, 150);
    c.y      = ($urandom_range(0, 1) == 1) ? $urandom_range(100, 127) : $urandom_range(0, 110);
    c.w      = $urandom_range(0, 12);
    c.h      = $urandom_range(0, 6);
    c.colour = $urandom_range(0, 7);
    c.spr    = $urandom_range(0, 63);
    c.transp = $urandom_range(0, 1);
    return c;
  endfunction

  // Issues c in the current (idle) cycle and checks every cycle up to and
  // including the first idle cycle afterwards. When hold is set, nxt is left
  // driven with cmd_valid=1 for the whole busy period.
  task automatic run_cmd(input cmd_t c, input bit hold, input cmd_t nxt, input string tag);
    int ox, oy, w, h, n, lat, last_k, base;
    bit empty;
    empty = 0; base = 0; lat = 1;
    ox = c.x; oy = c.y; w = c.w; h = c.h;
    case (c.op)
      0: begin ox = 0; oy = 0; w = SCREEN_W; h = SCREEN_H; end
      1: empty = (w == 0) || (h == 0);
      2: begin
        w = SPR_W; h = SPR_H; lat = 2;
        base = ((c.spr >= N_SPR) ? BACK_IDX : c.spr) * SPR_W * SPR_H;
      end
      default: empty = 1;
    endcase
    n      = empty ? 0 : w * h;
    last_k = empty ? 1 : lat + n - 1;

    check({tag, ".idle_wr"}, 32'(bus.waitrequest), 32'(0));
    drive(c, 1'b1);
    for (int k = 1; k <= last_k + 1; k++) begin
      int i, ex, ey, ecol;
      bit exp_plot;
      @(negedge clk);
      if (k == 1) drive(nxt, hold);
      i = k - lat;
      exp_plot = 0; ex = 0; ey = 0; ecol = 0;
      if (i >= 0 && i < n) begin
        ex   = ox + i % w;
        ey   = oy + i / w;
        ecol = (c.op == 2) ? int'(rom[base + i]) : c.colour;
        exp_plot = (ex < SCREEN_W) && (ey < SCREEN_H) && !(c.op == 2 && c.transp != 0 && ecol == 0);
      end
      check({tag, ".plot"}, 32'(vga_plot), 32'(exp_plot));
      if (exp_plot) begin
        check({tag, ".x"}, 32'(vga_x), 32'(ex));
        check({tag, ".y"}, 32'(vga_y), 32'(ey));
        check({tag, ".colour"}, 32'(vga_colour), 32'(ecol));
      end
      check({tag, ".done"}, 32'(bus.done), 32'(k == last_k));
      check({tag, ".waitreq"}, 32'(bus.waitrequest), 32'(k <= last_k));
      if (c.op == 2 && k <= n)
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'(base + k - 1));
      if (k == last_k + 1 && n > 0) begin
        int lx, ly, lcol;
        lx   = ox + (n - 1) % w;
        ly   = oy + (n - 1) / w;
        lcol = (c.op == 2) ? int'(rom[base + n - 1]) : c.colour;
        check({tag, ".hold_x"}, 32'(vga_x), 32'(lx & 255));
        check({tag, ".hold_y"}, 32'(vga_y), 32'(ly & 127));
        check({tag, ".hold_colour"}, 32'(vga_colour), 32'(lcol));
      end
    end
  endtask

  initial begin
    cmd_t c, c2;
    rst_n = 1'b0;
    c = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(c, 1'b0);
    for (int i = 0; i < ROM_N; i++)
      rom[i] = 3'($urandom_range(0, 7));
    // Sprite 9 gets guaranteed transparent entries.
    for (int i = 0; i < SPR_W * SPR_H; i++)
      if (i % 3 == 0) rom[9 * SPR_W * SPR_H + i] = '0;

    repeat (3) @(negedge clk);
    check("rst.waitreq", 32'(bus.waitrequest), 32'(0));
    check("rst.done", 32'(bus.done), 32'(0));
    check("rst.plot", 32'(vga_plot), 32'(0));
    check("rst.x", 32'(vga_x), 32'(0));
    check("rst.y", 32'(vga_y), 32'(0));
    check("rst.colour", 32'(vga_colour), 32'(0));
    check("rst.rom_addr", 32'(rom_addr), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(mk(1, 10, 20, 3, 2, 5, 0, 0), 1'b0, c, "rect");
    run_cmd(mk(0, 7, 9, 1, 1, 2, 0, 0), 1'b0, c, "clear");
    run_cmd(mk(2, 40, 30, 0, 0, 0, 5, 0), 1'b0, c, "spr5");
    run_cmd(mk(2, 0, 0, 0, 0, 0, 60, 0), 1'b0, c, "spr_back");
    run_cmd(mk(2, 155, 110, 0, 0, 0, 9, 1), 1'b0, c, "spr_clip");
    run_cmd(mk(1, 159, 119, 1, 1, 4, 0, 0), 1'b0, c, "rect1px");
    run_cmd(mk(1, 5, 5, 0, 4, 3, 0, 0), 1'b0, c, "rect_w0");
    run_cmd(mk(1, 5, 5, 4, 0, 3, 0, 0), 1'b0, c, "rect_h0");
    run_cmd(mk(3, 5, 5, 4, 4, 3, 0, 0), 1'b0, c, "op3");

    // Second command held valid during a busy period: taken once, at the first idle cycle.
    c2 = mk(1, 1, 2, 2, 2, 3, 0, 0);
    run_cmd(mk(1, 50, 60, 4, 3, 6, 0, 0), 1'b1, c2, "holdA");
    run_cmd(c2, 1'b0, c, "holdB");
    repeat (5) begin
      @(negedge clk);
      check("hold.idle_wr", 32'(bus.waitrequest), 32'(0));
      check("hold.idle_plot", 32'(vga_plot), 32'(0));
    end

    for (int r = 0; r < 60; r++)
      run_cmd(rand_cmd(), 1'b0, c, "rand");

    // Reset in the middle of a sprite aborts it with no done pulse.
    c2 = mk(2, 20, 20, 0, 0, 0, 7, 0);
    drive(c2, 1'b1);
    @(negedge clk);
    drive(c2, 1'b0);
    repeat (20) @(negedge clk);
    check("abort.busy_before", 32'(bus.waitrequest), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.plot", 32'(vga_plot), 32'(0));
    check("abort.done", 32'(bus.done), 32'(0));
    check("abort.waitreq", 32'(bus.waitrequest), 32'(0));
    check("abort.rom_addr", 32'(rom_addr), 32'(0));
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("abort.no_done", 32'(bus.done), 32'(0));
      check("abort.no_plot", 32'(vga_plot), 32'(0));
    end
    run_cmd(mk(1, 100, 100, 5, 3, 1, 0, 0), 1'b0, c, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
